// File: rtl/flight_pkg.sv
// Shared types and default constants for the lander thrust controller.
package flight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_POS,
    ST_RX_VEL,
    ST_COMPUTE,
    ST_FILTER,
    ST_SEND
  } state_t;

  localparam logic [31:0] START_CODE_DEF = 32'hAAAAAAAA;
  localparam int RADIUS_DEF      = 866816000;
  localparam int ALT_SHIFT_DEF   = 3;
  localparam int ALT_GAIN_DEF    = 36;
  localparam int GAIN_SHIFT_DEF  = 8;
  localparam int BIAS_DEF        = 128;
  localparam int DELTA_DEF       = 76;
  localparam int OUT_MAX_DEF     = 256;

  // Accumulator width that can hold NUM_AXES full-scale words without overflow.
  function automatic int acc_w(input int data_w, input int num_axes);
    return data_w + $clog2(num_axes) + 1;
  endfunction

endpackage

// File: rtl/flight_controller_nax_if.sv
// Word stream in, thrust command stream out.
// Handshake: in_valid is a one-cycle strobe with no backpressure; an output beat
// transfers on a cycle where out_valid && out_ready, and out_valid/out_data hold until then.
interface flight_controller_nax_if #(
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/fc_thrust_filter.sv
// Registered saturate/offset stage: maps the raw thrust term onto 0..OUT_MAX.
module fc_thrust_filter #(
  parameter int DATA_W  = 32,
  parameter int RAW_W   = 70,
  parameter int DELTA   = 76,
  parameter int OUT_MAX = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [RAW_W-1:0] raw,
  output logic [DATA_W-1:0]       cmd
);

  localparam logic signed [RAW_W-1:0] LO      = RAW_W'(-DELTA);
  localparam logic signed [RAW_W-1:0] HI      = RAW_W'(OUT_MAX - DELTA);
  localparam logic signed [RAW_W-1:0] DELTA_R = RAW_W'(DELTA);

  logic signed [RAW_W-1:0] offset;
  assign offset = raw + DELTA_R;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd <= '0;
    end else if (en) begin
      if (raw <= LO)      cmd <= '0;
      else if (raw >= HI) cmd <= DATA_W'(OUT_MAX);
      else                cmd <= DATA_W'(offset);
    end
  end

endmodule

// File: rtl/flight_controller_nax.sv
// Lander thrust controller: collects a position/velocity packet, computes one
// saturated thrust command and hands it downstream.
module flight_controller_nax
  import flight_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                NUM_AXES       = 3,
  parameter logic [DATA_W-1:0] START_CODE     = DATA_W'(START_CODE_DEF),
  parameter int                RADIUS         = RADIUS_DEF,
  parameter int                ALT_SHIFT      = ALT_SHIFT_DEF,
  parameter int                ALT_GAIN       = ALT_GAIN_DEF,
  parameter int                GAIN_SHIFT     = GAIN_SHIFT_DEF,
  parameter int                BIAS           = BIAS_DEF,
  parameter int                DELTA          = DELTA_DEF,
  parameter int                OUT_MAX        = OUT_MAX_DEF,
  parameter int                COMPUTE_CYCLES = 100,
  parameter int                TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  flight_controller_nax_if.slave        io,
  output logic                          busy,
  output logic                          err_timeout,
  output logic                          err_drop,
  output logic [15:0]                   pkt_count,
  output state_t                        state_dbg
);

  localparam int ACC_W = acc_w(DATA_W, NUM_AXES);
  localparam int RAW_W = 2 * ACC_W;
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MAX_POS  = ~MOST_NEG;

  state_t                  state;
  logic signed [ACC_W-1:0] pos_sum, vel_sum;
  logic [3:0]              axis_idx;
  logic [31:0]             wd_cnt, cmp_cnt;
  logic signed [RAW_W-1:0] raw, raw_next, alt_term, pos_w, vel_w;
  logic signed [DATA_W-1:0] word_s, word_abs;
  logic                    is_start, last_axis, wd_expired;

  assign word_s     = io.in_data;
  assign is_start   = (io.in_data == START_CODE);
  assign last_axis  = (axis_idx == 4'(NUM_AXES - 1));
  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;

  // The most negative word has no positive twin, so its magnitude clips to MAX_POS.
  always_comb begin
    word_abs = word_s;
    if (word_s == MOST_NEG) word_abs = MAX_POS;
    else if (word_s < 0)    word_abs = -word_s;
  end

  always_comb begin
    pos_w    = RAW_W'(pos_sum);
    vel_w    = RAW_W'(vel_sum);
    alt_term = (((pos_w - RAW_W'(RADIUS)) >>> ALT_SHIFT) * RAW_W'(ALT_GAIN)) >>> GAIN_SHIFT;
    raw_next = vel_w - RAW_W'(BIAS) - alt_term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pos_sum      <= '0;
      vel_sum      <= '0;
      axis_idx     <= '0;
      wd_cnt       <= '0;
      cmp_cnt      <= '0;
      raw          <= '0;
      io.out_valid <= 1'b0;
      err_timeout  <= 1'b0;
      err_drop     <= 1'b0;
      pkt_count    <= '0;
    end else begin
      err_timeout <= 1'b0;
      err_drop    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (io.in_valid && is_start) begin
            state    <= ST_RX_POS;
            pos_sum  <= '0;
            vel_sum  <= '0;
            axis_idx <= '0;
            wd_cnt   <= '0;
          end
        end
        ST_RX_POS, ST_RX_VEL: begin
          if (io.in_valid) begin
            wd_cnt <= '0;
            if (is_start) begin
              state    <= ST_RX_POS;
              pos_sum  <= '0;
              vel_sum  <= '0;
              axis_idx <= '0;
            end else begin
              if (state == ST_RX_POS) pos_sum <= pos_sum + ACC_W'(word_abs);
              else                    vel_sum <= vel_sum + ACC_W'(word_s);
              if (last_axis) begin
                axis_idx <= '0;
                cmp_cnt  <= '0;
                state    <= (state == ST_RX_POS) ? ST_RX_VEL : ST_COMPUTE;
              end else begin
                axis_idx <= axis_idx + 4'd1;
              end
            end
          end else if (wd_expired) begin
            state       <= ST_IDLE;
            err_timeout <= 1'b1;
            pos_sum     <= '0;
            vel_sum     <= '0;
            axis_idx    <= '0;
            wd_cnt      <= '0;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        ST_COMPUTE: begin
          err_drop <= io.in_valid;
          if (cmp_cnt == '0) raw <= raw_next;
          if (cmp_cnt == 32'(COMPUTE_CYCLES - 1)) begin
            cmp_cnt <= '0;
            state   <= ST_FILTER;
          end else begin
            cmp_cnt <= cmp_cnt + 32'd1;
          end
        end
        ST_FILTER: begin
          err_drop     <= io.in_valid;
          io.out_valid <= 1'b1;
          state        <= ST_SEND;
        end
        ST_SEND: begin
          err_drop <= io.in_valid;
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            pkt_count    <= pkt_count + 16'd1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fc_thrust_filter #(
    .DATA_W (DATA_W),
    .RAW_W  (RAW_W),
    .DELTA  (DELTA),
    .OUT_MAX(OUT_MAX)
  ) u_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == ST_FILTER),
    .raw  (raw),
    .cmd  (io.out_data)
  );

endmodule
